// File: rtl/decode_stage.sv
// decode_stage
//   Instruction decode stage sitting in front of the 16 x 32-bit register file.
//   Splits the instruction into fields, drives the register-file read
//   addresses, and captures the read data plus decoded controls into a
//   one-entry ID/EX register. A busy bit per register (set on accept of a
//   writing instruction, cleared by writeback) holds back any instruction
//   whose sources or destination still have a write in flight.
//
// Ports
//   clk, reset            clock (rising edge), async active-high reset
//   in_valid / in_ready   instruction handshake
//   instr                 [31:28] op, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm16
//   readReg1/readReg2     register-file read addresses (rs1 / rs2)
//   readData1/readData2   register-file read data, same cycle
//   wb_valid, wb_reg      writeback commit, clears the register's busy bit
//   flush                 discard the ID/EX entry
//   out_valid / out_ready ID/EX handshake
//   out_op, out_rd, out_a, out_b, out_imm, out_reg_write, out_mem_read,
//   out_mem_write, out_illegal   captured decode results
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    output logic [REG_AW-1:0] readReg1,
    output logic [REG_AW-1:0] readReg2,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_illegal
);

    localparam int NREGS = 1 << REG_AW;

    logic [3:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] immExt;

    logic useRs1, useRs2, writesRd, memRead, memWrite, illegal;
    logic stall, accept;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busyNext;

    assign opcode = instr[31:28];
    assign rd     = instr[24 +: REG_AW];
    assign rs1    = instr[20 +: REG_AW];
    assign rs2    = instr[16 +: REG_AW];
    assign imm16  = instr[15:0];
    assign immExt = {{(DATA_W-16){imm16[15]}}, imm16};

    assign readReg1 = rs1;
    assign readReg2 = rs2;

    always_comb begin
        useRs1   = 1'b0;
        useRs2   = 1'b0;
        writesRd = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            4'd0: ;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                useRs1   = 1'b1;
                useRs2   = 1'b1;
                writesRd = 1'b1;
            end
            4'd6: begin
                useRs1   = 1'b1;
                writesRd = 1'b1;
            end
            4'd7: begin
                useRs1   = 1'b1;
                writesRd = 1'b1;
                memRead  = 1'b1;
            end
            4'd8: begin
                useRs1   = 1'b1;
                useRs2   = 1'b1;
                memWrite = 1'b1;
            end
            4'd9: begin
                useRs1 = 1'b1;
                useRs2 = 1'b1;
            end
            4'd10: writesRd = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // Registered busy only: a writeback clearing a register this cycle does
    // not release a waiting instruction until the next cycle.
    assign stall = in_valid & ((useRs1 & busy[rs1]) |
                               (useRs2 & busy[rs2]) |
                               (writesRd & busy[rd]));

    assign in_ready = ~stall & (~out_valid | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;

    // Ordering gives set priority over any clear of the same register.
    always_comb begin
        busyNext = busy;
        if (wb_valid)
            busyNext[wb_reg] = 1'b0;
        if (flush && out_valid && out_reg_write)
            busyNext[out_rd] = 1'b0;
        if (accept && writesRd)
            busyNext[rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= '0;
        else
            busy <= busyNext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_op        <= '0;
            out_rd        <= '0;
            out_a         <= '0;
            out_b         <= '0;
            out_imm       <= '0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
            out_mem_write <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_op        <= opcode;
            out_rd        <= rd;
            out_a         <= readData1;
            out_b         <= readData2;
            out_imm       <= immExt;
            out_reg_write <= writesRd;
            out_mem_read  <= memRead;
            out_mem_write <= memWrite;
            out_illegal   <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [3:0]  readReg1, readReg2;
    logic [31:0] readData1 = '0, readData2 = '0;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_reg = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_op, out_rd;
    logic [31:0] out_a, out_b, out_imm;
    logic        out_reg_write, out_mem_read, out_mem_write, out_illegal;

    decode_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .readReg1(readReg1), .readReg2(readReg2),
        .readData1(readData1), .readData2(readData2),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_a(out_a), .out_b(out_b),
        .out_imm(out_imm), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [3:0]  ctl;   // {reg_write, mem_read, mem_write, illegal}
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   nPass = 0;
    int   nTotal = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            nPass++;
    endtask

    // Monitor: compares the presented entry against the scoreboard head on
    // every valid cycle; pops on consume or flush.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                nTotal++;
                $display("FAIL sb_underflow: out_valid with no expected entry (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb[0];
                chk("out_op", {28'd0, out_op}, {28'd0, e.op});
                if (flush) begin
                    void'(sb.pop_front());
                end else begin
                    chk("out_rd", {28'd0, out_rd}, {28'd0, e.rd});
                    chk("out_a", out_a, e.a);
                    chk("out_b", out_b, e.b);
                    chk("out_imm", out_imm, e.imm);
                    chk("out_ctl", {28'd0, out_reg_write, out_mem_read, out_mem_write, out_illegal},
                        {28'd0, e.ctl});
                    if (out_ready)
                        void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] expImm, input logic [3:0] ctl);
        instr     = ins;
        readData1 = d1;
        readData2 = d2;
        in_valid  = 1'b1;
        pend.op   = ins[31:28];
        pend.rd   = ins[27:24];
        pend.a    = d1;
        pend.b    = d2;
        pend.imm  = expImm;
        pend.ctl  = ctl;
    endtask

    task automatic waitAccept(output int waits);
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            nTotal++;
            $display("FAIL accept_timeout: in_ready stayed 0 for instr 0x%0h", instr);
            in_valid = 1'b0;
        end else begin
            sb.push_back(pend);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    int w;

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {16'd0, dut.busy}, 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;

        // ADD r3,r1,r2
        drive(32'h13120000, 32'd5, 32'd7, 32'd0, 4'b1000);
        waitAccept(w);
        chk("add_wait", w, 32'd0);
        chk("add_busy3", {31'd0, dut.busy[3]}, 32'd1);

        // SUB r4,r3,r1 waits on r3 until writeback is registered
        drive(32'h24310000, 32'd12, 32'd5, 32'd0, 4'b1000);
        @(negedge clk);
        chk("sub_stall", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 wb_valid = 1'b1; wb_reg = 4'd3;
        @(negedge clk);
        chk("sub_no_bypass", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 wb_valid = 1'b0;
        waitAccept(w);
        chk("sub_release", w, 32'd0);

        // ADD r2,r0,r1 marks r2 busy
        drive(32'h12010000, 32'd1, 32'd2, 32'd0, 4'b1000);
        waitAccept(w);

        // ADDI r5,r0,0xFFF0 with rs2 field = busy r2: must not stall
        drive(32'h6502FFF0, 32'd9, 32'hDEAD, 32'hFFFFFFF0, 4'b1000);
        waitAccept(w);
        chk("addi_nostall", w, 32'd0);
        out_ready = 1'b0;

        // XOR r7,r1,r1 held off by back-pressure for 3 cycles
        drive(32'h57110000, 32'd3, 32'd3, 32'd0, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        waitAccept(w);
        chk("bp_drain_load", w, 32'd0);

        // LW r6,4(r1) then flush while held
        drive(32'h76100004, 32'h100, 32'h55, 32'd4, 4'b1100);
        waitAccept(w);
        out_ready = 1'b0;
        chk("lw_busy6", {31'd0, dut.busy[6]}, 32'd1);
        @(posedge clk);
        #1 flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_busy6", {31'd0, dut.busy[6]}, 32'd0);

        // Illegal opcode 0xE, rs2 = busy r2, rd = busy r7: never stalls
        drive(32'hE7120000, 32'h11, 32'h22, 32'd0, 4'b0001);
        waitAccept(w);
        chk("ill_nostall", w, 32'd0);
        chk("ill_busy", {16'd0, dut.busy}, 32'h000000B4);

        // Writeback of a register that is not busy
        wb_valid = 1'b1; wb_reg = 4'd9;
        @(posedge clk);
        #1 wb_valid = 1'b0;
        chk("wb_idle_busy", {16'd0, dut.busy}, 32'h000000B4);

        // OR r8,r1,r1 accepted while wb clears r8: set wins
        drive(32'h48110000, 32'd6, 32'd6, 32'd0, 4'b1000);
        wb_valid = 1'b1; wb_reg = 4'd8;
        waitAccept(w);
        wb_valid = 1'b0;
        out_ready = 1'b0;
        chk("setclr_busy", {16'd0, dut.busy}, 32'h000001B4);

        // AND r9,r4,r1 stalls on r4; async reset mid-cycle
        drive(32'h39410000, 32'd1, 32'd1, 32'd0, 4'b1000);
        @(negedge clk);
        chk("and_stall", {31'd0, in_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_busy", {16'd0, dut.busy}, 32'd0);
        chk("arst_out_op", {28'd0, out_op}, 32'd0);
        chk("arst_out_a", out_a, 32'd0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage, directly upstream of the Registers block (16 x 32-bit register file).
- Splits each 32-bit instruction into fields and drives readReg1/readReg2 to the register file.
- Captures readData1/readData2 plus decoded controls into a one-entry ID/EX output register.
- A 16-bit busy scoreboard stalls an instruction whose source or destination register has a write still pending from writeback.

Parameters:
- DATA_W, 32, operand and instruction width.
- REG_AW, 4, register address width (2^REG_AW registers).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  instr is valid
- in_ready  out  1  stage accepts instr this cycle
- instr  in  32  [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm16
- readReg1  out  4  to register file, equals instr[23:20]
- readReg2  out  4  to register file, equals instr[19:16]
- readData1  in  32  register file read data, combinational, same cycle
- readData2  in  32  register file read data, combinational, same cycle
- wb_valid  in  1  writeback committing a register write this cycle
- wb_reg  in  4  register being written back
- flush  in  1  discard output entry
- out_valid  out  1  ID/EX entry valid
- out_ready  in  1  execute stage consumes entry
- out_op  out  4  opcode
- out_rd  out  4  destination register
- out_a  out  32  rs1 value
- out_b  out  32  rs2 value
- out_imm  out  32  sign-extended imm16
- out_reg_write  out  1  instruction writes rd
- out_mem_read  out  1  load
- out_mem_write  out  1  store
- out_illegal  out  1  undefined opcode

Behaviour:
- Opcodes and their source/destination use (use_rs1, use_rs2, writes rd):
  - 0 NOP: none.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rs1, rs2, rd.
  - 6 ADDI: rs1, rd.
  - 7 LW: rs1, rd; mem_read.
  - 8 SW: rs1, rs2; mem_write.
  - 9 BEQ: rs1, rs2.
  - 10 LUI: rd only.
  - 11–15: illegal. Decoded as NOP with out_illegal=1; no reads, no write, never stalls.
- Register 0 is an ordinary register; there is no hardwired zero.
- stall = in_valid & ((use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]) | (writes & busy[rd])).
- busy is the registered value; there is no bypass of the same-cycle wb clear.
- in_ready = ~stall & (~out_valid | out_ready) & ~flush.
- Accept = in_valid & in_ready.
  - On the clock edge, all out_* load the decoded fields, out_a=readData1 and out_b=readData2, and out_valid=1.
  - Latency is 1 cycle, accept to out_valid.
- out_valid & out_ready with no accept: out_valid clears to 0. Data outputs hold their last value.
- While out_valid=1 and out_ready=0, all out_* hold stable.
- Scoreboard:
  - An accept with writes=1 sets busy[rd].
  - wb_valid clears busy[wb_reg].
  - Set and clear of the same register in the same cycle: set wins.
  - wb_valid for a register that is not busy: no effect.
- flush:
  - Forces out_valid=0 on the next edge.
  - If the discarded entry had out_reg_write=1, its busy[out_rd] clears; an explicit wb clear in the same cycle is harmless.
  - No accept occurs in a flush cycle.
  - Busy bits of instructions already past execute are untouched.
- Reset (asynchronous, immediate):
  - out_valid=0, busy=16'h0000, and all out_* data/control = 0.
  - in_ready follows its equation, so it is 1 once reset deasserts.
  - A mid-operation reset drops the held entry and every pending busy bit.
- out_imm = {{16{imm16[15]}}, imm16} for all opcodes.
- LUI: execute uses out_imm. No special shift is applied here.

Test Plan:
- Reset, then ADD r3,r1,r2 (instr=0x13120000) with readData1=5, readData2=7, out_ready=1 -> one cycle later out_valid=1, out_op=1, out_rd=3, out_a=5, out_b=7, out_reg_write=1; busy[3]=1.
- ADD r3,r1,r2 then SUB r4,r3,r1 back-to-back -> SUB held with in_ready=0. Assert wb_valid, wb_reg=3 -> in_ready=1 on the following cycle and SUB is accepted.
- ADDI r5,r0,imm=0xFFF0 -> out_imm=0xFFFFFFF0, out_b ignored, no stall even if busy[r2] is set.
- out_ready=0 for 3 cycles with a valid entry -> outputs stable, in_ready=0. out_ready=1 -> entry drains; the next instruction loads the same edge.
- Flush with held LW r6 (out_reg_write=1) -> out_valid=0 next cycle, busy[6]=0, in_ready=0 during the flush cycle.
- Opcode 0xE -> out_illegal=1, out_reg_write=0, no busy change. Async reset mid-stall -> out_valid=0 and busy=0 immediately, without a clock edge.
